// File: rtl/fifo_sync_flags.sv
// Synchronous single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, standard or first-word-fall-through read mode, and overflow/underflow pulses.
module fifo_sync_flags #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DWIDTH-1:0]     din,
  input  logic                  rd_en,
  output logic [DWIDTH-1:0]     dout,
  output logic                  valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LVL = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL = AE_THRESH[ADDR_WIDTH:0];

  logic [DWIDTH-1:0]     mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr, rptr;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic                  wr_acc, rd_acc;

  assign waddr = wptr[ADDR_WIDTH-1:0];
  assign raddr = rptr[ADDR_WIDTH-1:0];

  // The extra pointer MSB distinguishes full from empty when the low bits match.
  assign count        = wptr - rptr;
  assign empty        = (wptr == rptr);
  assign full         = (waddr == raddr) && (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  // NOTE: the storage array has no reset; clearing it would cost a reset fan-out to
  // every word and the pointers alone already define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[waddr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is always presented; rd_en acknowledges it.
      assign dout  = mem[raddr];
      assign valid = !empty;
    end else begin : g_std
      // A simultaneous write to the same slot at full does not disturb this read:
      // the register captures the old word before the memory update lands.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout  <= '0;
          valid <= 1'b0;
        end else begin
          valid <= rd_acc;
          if (rd_acc) dout <= mem[raddr];
        end
      end
    end
  endgenerate

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Parametrised synchronous single-clock FIFO. It is the next generation of the team's sample buffer between the sensor/ADC front end and the PID loop.
- Over the previous block it adds:
  - all 2**ADDR_WIDTH entries usable (extra pointer MSB)
  - occupancy count
  - programmable almost-full/almost-empty thresholds
  - selectable standard or first-word-fall-through (FWFT) read mode
  - overflow/underflow error pulses

Parameters:
- DWIDTH, 16, width of each data word.
- ADDR_WIDTH, 3, depth = 2**ADDR_WIDTH words, all usable (default 8).
- FWFT, 0, read mode: 0 = registered read (1-cycle latency), 1 = first-word-fall-through.
- AF_THRESH, 6, almost_full asserted when count >= AF_THRESH. Legal range 1..2**ADDR_WIDTH.
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH. Legal range 0..2**ADDR_WIDTH-1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset rst, synchronous, active-high.
- wr_en  input  1  write request.
- din  input  DWIDTH  write data.
- rd_en  input  1  read request / pop.
- dout  output  DWIDTH  read data.
- valid  output  1  dout holds a freshly read word.
- empty  output  1  count == 0.
- full  output  1  count == 2**ADDR_WIDTH.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- overflow  output  1  one-cycle pulse: a write was rejected.
- underflow  output  1  one-cycle pulse: a read was rejected.

Behaviour:
- Pointers: wptr and rptr are ADDR_WIDTH+1 bits. Memory is indexed by the low ADDR_WIDTH bits.
  - count = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - Wrap-around is natural modulo arithmetic.
- Flags: empty, full, almost_full, almost_empty and count are combinational from the registered pointers only. No combinational path exists from wr_en/rd_en to any flag.
- Write acceptance: wr_acc = wr_en && (!full || rd_acc). On acceptance, mem[wptr] <= din and wptr increments at the edge.
- Read acceptance: rd_acc = rd_en && !empty. On acceptance, rptr increments at the edge.
- Simultaneous wr_en and rd_en:
  - Full: both are accepted and count is unchanged.
  - Empty: the write is accepted and the read is rejected (underflow pulse). There is no same-cycle bypass.
- Standard mode (FWFT=0):
  - On rd_acc, dout <= mem[rptr] at the edge and valid = 1 for exactly the following cycle.
  - Otherwise valid = 0 and dout holds its last value.
- FWFT mode (FWFT=1):
  - dout = mem[rptr[ADDR_WIDTH-1:0]] continuously and valid = !empty.
  - rd_en acts as an acknowledge of the presented word.
  - A word written into an empty FIFO appears on dout, with valid = 1, in the cycle after the write edge.
- Error pulses:
  - overflow <= wr_en && !wr_acc.
  - underflow <= rd_en && !rd_acc.
  - Both are registered, so each pulse is high for the single cycle after the offending request.
  - A rejected request never changes pointers, memory or dout.
- Reset:
  - wptr = rptr = 0, so empty = 1, full = 0 and count = 0.
  - almost_empty = 1 (for AE_THRESH >= 0) and almost_full = 0.
  - dout = 0, valid = 0, overflow = 0, underflow = 0.
  - Memory contents are not cleared.
  - Reset overrides any wr_en/rd_en in the same cycle.
  - Reset mid-operation discards all stored words; reads after reset see empty.
- Latency:
  - Write to empty deasserting: 1 edge.
  - Standard-mode read to valid data: 1 edge.

Test Plan:
- Fill/full (FWFT=0, ADDR_WIDTH=3): write 0x0001..0x0008 on consecutive cycles -> count steps 1..8; almost_full rises at count 6; full = 1 after the 8th edge. A 9th write with din=0xDEAD -> overflow pulses for 1 cycle, count stays 8.
- Drain/order: from full, assert rd_en for 8 cycles -> dout = 0x0001..0x0008 each with valid = 1 one cycle after each rd_en; empty = 1 after the 8th read; almost_empty rises at count 1. A 9th rd_en -> underflow pulse, dout holds 0x0008, valid = 0.
- Simultaneous: at full, wr_en = rd_en = 1 with din=0x00AA -> count stays 8, no overflow, 0x00AA is read out 8 reads later. At empty, wr_en = rd_en = 1 with din=0x0055 -> count = 1, underflow pulse, no valid.
- Wrap-around: 20 cycles of interleaved single write then single read with din = cycle index -> every read returns its written value and count alternates 1/0 across pointer wrap.
- FWFT=1: write 0x1234 into empty -> next cycle dout = 0x1234, valid = 1 without rd_en. Then rd_en for 1 cycle -> empty = 1, valid = 0.
- Reset mid-operation: after 5 writes, pulse rst for 1 cycle while wr_en = 1 -> count = 0, empty = 1, dout = 0, valid = 0, no overflow/underflow. A subsequent write/read returns only the new data.
